// File: rtl/cond_unit.sv
// Conditional-execution stage: holds the NZCV flag register, evaluates the
// ARM condition field against it and gates the decoder's write strobes.
// With PIPE_OUT=1 the gated strobes leave through an output register.
module cond_unit #(
  parameter bit PIPE_OUT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       cond_ex,
  output logic       undef,
  output logic [3:0] flags
);

  // Registered architectural flags {N,Z,C,V}
  logic [3:0] flags_p1;
  // Gated strobes {pcs, reg_w, mem_w} for the current instruction
  logic [2:0] strobes_p0;

  // Condition-code evaluation against a flag vector {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cf;
      4'b0011: r = ~cf;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cf & ~z;
      4'b1001: r = ~cf | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational condition check on the pre-update flags
  assign undef      = (cond == 4'b1111);
  assign cond_ex    = cond_pass(cond, flags_p1) & ~flush;
  assign strobes_p0 = {pcs, reg_w, mem_w} & {3{cond_ex}};
  assign flags      = flags_p1;

  // Flag register: N,Z and C,V halves update independently on a passing instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_p1 <= 4'b0000;
    end else if (en && cond_ex) begin
      if (flag_w[1]) flags_p1[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flags_p1[1:0] <= alu_flags[1:0];
    end
  end

  // Stage p1: optional output register for the gated strobes
  generate
    if (PIPE_OUT) begin : g_pipe
      logic [2:0] strobes_p1;

      // Flush clears the register even while stalled; a stall alone holds it
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          strobes_p1 <= 3'b000;
        end else if (flush) begin
          strobes_p1 <= 3'b000;
        end else if (en) begin
          strobes_p1 <= strobes_p0;
        end
      end

      assign {pc_src, reg_write, mem_write} = strobes_p1;
    end else begin : g_comb
      assign {pc_src, reg_write, mem_write} = strobes_p0;
    end
  endgenerate

endmodule
